// File: rtl/fifo_shadow_checker.sv
// Passive protocol checker for a ready/valid-in, valid/yumi-out FIFO.
// It keeps a shadow copy of the queue, checks flags, data order and post-reset state, and collects occupancy coverage.
module fifo_shadow_checker #(
  parameter  int WIDTH_P     = 8,
  parameter  int CAP_P       = 8,
  parameter  int CNT_W_P     = 16,
  parameter  int CHK_FLAGS_P = 1,
  localparam int OCC_W       = $clog2(CAP_P + 1),
  localparam int PTR_W       = $clog2(CAP_P)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               valid_i,
  input  logic               ready_o,
  input  logic [WIDTH_P-1:0] data_i,
  input  logic               valid_o,
  input  logic [WIDTH_P-1:0] data_o,
  input  logic               yumi_i,
  output logic               res_err_p,
  output logic               data_err_p,
  output logic               flag_err_p,
  output logic [CNT_W_P-1:0] res_err_cnt,
  output logic [CNT_W_P-1:0] data_err_cnt,
  output logic [CNT_W_P-1:0] flag_err_cnt,
  output logic [OCC_W-1:0]   occ,
  output logic [CAP_P-1:0]   enq_cov,
  output logic [CAP_P-1:0]   deq_cov,
  output logic [CAP_P-2:0]   both_cov
);

  localparam logic [OCC_W-1:0] CAP_OCC = OCC_W'(CAP_P);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(CAP_P - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_MAX) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  function automatic logic [CNT_W_P-1:0] sat_inc(input logic [CNT_W_P-1:0] c, input logic e);
    if (e && (c != {CNT_W_P{1'b1}})) begin
      return c + CNT_W_P'(1);
    end else begin
      return c;
    end
  endfunction

  logic [WIDTH_P-1:0] mem_q [CAP_P];
  logic               arm_q;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               res_p_q, res_p_d, data_p_q, data_p_d, flag_p_q, flag_p_d;
  logic [CNT_W_P-1:0] res_cnt_q, res_cnt_d, data_cnt_q, data_cnt_d, flag_cnt_q, flag_cnt_d;
  logic [CAP_P-1:0]   enq_cov_q, enq_cov_d, deq_cov_q, deq_cov_d;
  logic [CAP_P-2:0]   both_cov_q, both_cov_d;

  logic live_s, enq_s, deq_s, not_full_s, not_empty_s, push_s, pop_s;
  logic flag_mis_s, enq_only_s, deq_only_s, both_s;

  // Event decode; everything except the reset check is masked while armed.
  always_comb begin
    live_s      = ~arm_q;
    enq_s       = valid_i & ready_o;
    deq_s       = valid_o & yumi_i;
    not_full_s  = (occ_q != CAP_OCC);
    not_empty_s = (occ_q != '0);
    pop_s       = live_s & deq_s & not_empty_s;
    push_s      = live_s & enq_s & (not_full_s | deq_s);
    flag_mis_s  = (CHK_FLAGS_P != 0) &&
                  ((ready_o != not_full_s) || (valid_o != not_empty_s));
    enq_only_s  = live_s & enq_s & ~deq_s & not_full_s;
    deq_only_s  = live_s & deq_s & ~enq_s & not_empty_s;
    both_s      = live_s & enq_s & deq_s & not_empty_s & not_full_s;
  end

  // Next-state for pulses, counters, shadow pointers, occupancy and coverage.
  always_comb begin
    res_p_d  = arm_q & (~ready_o | valid_o);
    flag_p_d = live_s & (flag_mis_s | (deq_s & ~not_empty_s) | (enq_s & ~deq_s & ~not_full_s));
    data_p_d = pop_s && (data_o != mem_q[head_q]);

    if (pop_s) begin
      head_d = ptr_inc(head_q);
    end else begin
      head_d = head_q;
    end
    if (push_s) begin
      tail_d = ptr_inc(tail_q);
    end else begin
      tail_d = tail_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    for (int k = 0; k < CAP_P; k++) begin
      enq_cov_d[k] = enq_cov_q[k] | (enq_only_s & (occ_q == OCC_W'(k)));
      deq_cov_d[k] = deq_cov_q[k] | (deq_only_s & (occ_q == OCC_W'(k + 1)));
    end
    for (int k = 0; k < CAP_P - 1; k++) begin
      both_cov_d[k] = both_cov_q[k] | (both_s & (occ_q == OCC_W'(k + 1)));
    end

    res_cnt_d  = sat_inc(res_cnt_q, res_p_d);
    data_cnt_d = sat_inc(data_cnt_q, data_p_d);
    flag_cnt_d = sat_inc(flag_cnt_q, flag_p_d);
  end

  // State registers; reset discards the shadow queue and arms the reset check.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      arm_q      <= 1'b1;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      res_p_q    <= 1'b0;
      data_p_q   <= 1'b0;
      flag_p_q   <= 1'b0;
      res_cnt_q  <= '0;
      data_cnt_q <= '0;
      flag_cnt_q <= '0;
      enq_cov_q  <= '0;
      deq_cov_q  <= '0;
      both_cov_q <= '0;
    end else begin
      arm_q      <= 1'b0;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      res_p_q    <= res_p_d;
      data_p_q   <= data_p_d;
      flag_p_q   <= flag_p_d;
      res_cnt_q  <= res_cnt_d;
      data_cnt_q <= data_cnt_d;
      flag_cnt_q <= flag_cnt_d;
      enq_cov_q  <= enq_cov_d;
      deq_cov_q  <= deq_cov_d;
      both_cov_q <= both_cov_d;
    end
  end

  // Shadow storage.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < CAP_P; k++) begin
        mem_q[k] <= '0;
      end
    end else if (push_s) begin
      mem_q[tail_q] <= data_i;
    end else begin
      mem_q[tail_q] <= mem_q[tail_q];
    end
  end

  assign res_err_p    = res_p_q;
  assign data_err_p   = data_p_q;
  assign flag_err_p   = flag_p_q;
  assign res_err_cnt  = res_cnt_q;
  assign data_err_cnt = data_cnt_q;
  assign flag_err_cnt = flag_cnt_q;
  assign occ          = occ_q;
  assign enq_cov      = enq_cov_q;
  assign deq_cov      = deq_cov_q;
  assign both_cov     = both_cov_q;

endmodule

// File: tb/tb_fifo_shadow_checker.sv
// Directed bench for fifo_shadow_checker: the bench plays a FIFO, driving its ports with a vector table and some scripted sequences.
module tb_fifo_shadow_checker;
  localparam int W   = 8;
  localparam int CAP = 4;
  localparam int CW  = 4;

  logic clk_i = 1'b0;
  logic reset_n_i;
  logic valid_i, ready_o, valid_o, yumi_i;
  logic [W-1:0] data_i, data_o;
  logic res_err_p, data_err_p, flag_err_p;
  logic [CW-1:0] res_err_cnt, data_err_cnt, flag_err_cnt;
  logic [2:0] occ;
  logic [CAP-1:0] enq_cov, deq_cov;
  logic [CAP-2:0] both_cov;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  fifo_shadow_checker #(.WIDTH_P(W), .CAP_P(CAP), .CNT_W_P(CW), .CHK_FLAGS_P(1)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .valid_o(valid_o), .data_o(data_o), .yumi_i(yumi_i),
    .res_err_p(res_err_p), .data_err_p(data_err_p), .flag_err_p(flag_err_p),
    .res_err_cnt(res_err_cnt), .data_err_cnt(data_err_cnt), .flag_err_cnt(flag_err_cnt),
    .occ(occ), .enq_cov(enq_cov), .deq_cov(deq_cov), .both_cov(both_cov)
  );

  typedef struct {
    logic       vi;
    logic       ro;
    logic [7:0] di;
    logic       vo;
    logic [7:0] dout;
    logic       yi;
    logic [2:0] occ;
    logic       res;
    logic       dat;
    logic       flg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic vi, logic ro, logic [7:0] di, logic vo, logic [7:0] dout,
                              logic yi, logic [2:0] o, logic res, logic dat, logic flg);
    vec_t v;
    v.vi = vi; v.ro = ro; v.di = di; v.vo = vo; v.dout = dout; v.yi = yi;
    v.occ = o; v.res = res; v.dat = dat; v.flg = flg;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic vi, input logic ro, input logic [7:0] di,
                       input logic vo, input logic [7:0] dout, input logic yi);
    valid_i = vi; ready_o = ro; data_i = di; valid_o = vo; data_o = dout; yumi_i = yi;
  endtask

  task automatic step(input string nm, input logic [2:0] o, input logic res,
                      input logic dat, input logic flg);
    @(posedge clk_i);
    #1;
    chk({nm, ".occ"}, 32'(occ), 32'(o));
    chk({nm, ".res_p"}, 32'(res_err_p), 32'(res));
    chk({nm, ".data_p"}, 32'(data_err_p), 32'(dat));
    chk({nm, ".flag_p"}, 32'(flag_err_p), 32'(flg));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".occ"}, 32'(occ), 32'h0);
    chk({nm, ".pulses"}, 32'({res_err_p, data_err_p, flag_err_p}), 32'h0);
    chk({nm, ".cnts"}, 32'({res_err_cnt, data_err_cnt, flag_err_cnt}), 32'h0);
    chk({nm, ".covs"}, 32'({enq_cov, deq_cov, both_cov}), 32'h0);
  endtask

  initial begin
    logic [7:0] d;
    // Correct FIFO: fill 11..44, drain.
    vecs.push_back(mk(0, 1, 8'h00, 0, 8'h00, 0, 3'd0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h11, 0, 8'h00, 0, 3'd1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h22, 1, 8'h11, 0, 3'd2, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h33, 1, 8'h11, 0, 3'd3, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h44, 1, 8'h11, 0, 3'd4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h11, 1, 3'd3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h22, 1, 3'd2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h33, 1, 3'd1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h44, 1, 3'd0, 0, 0, 0));
    // Wrong head data on the second dequeue.
    vecs.push_back(mk(1, 1, 8'h55, 0, 8'h00, 0, 3'd1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h66, 1, 8'h55, 0, 3'd2, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h77, 1, 8'h55, 0, 3'd3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h55, 1, 3'd2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h99, 1, 3'd1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'h77, 1, 3'd0, 0, 0, 0));
    // Fill, then ready_o wrongly high at full with valid_i.
    vecs.push_back(mk(1, 1, 8'ha1, 0, 8'h00, 0, 3'd1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'ha2, 1, 8'ha1, 0, 3'd2, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'ha3, 1, 8'ha1, 0, 3'd3, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'ha4, 1, 8'ha1, 0, 3'd4, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hff, 1, 8'ha1, 0, 3'd4, 0, 0, 1));
    // Simultaneous enq+deq at occupancy 3, 2, 1.
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'ha1, 1, 3'd3, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hb1, 1, 8'ha2, 1, 3'd3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'ha3, 1, 3'd2, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hb2, 1, 8'ha4, 1, 3'd2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'hb1, 1, 3'd1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hb3, 1, 8'hb2, 1, 3'd1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 8'hb3, 1, 3'd0, 0, 0, 0));

    reset_n_i = 1'b0;
    drive(0, 1, 8'h00, 0, 8'h00, 0);
    repeat (2) @(posedge clk_i);
    #1;
    chk_all_zero("reset");
    @(negedge clk_i);
    reset_n_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].vi, vecs[i].ro, vecs[i].di, vecs[i].vo, vecs[i].dout, vecs[i].yi);
      step($sformatf("vec%0d", i), vecs[i].occ, vecs[i].res, vecs[i].dat, vecs[i].flg);
      if (i == 8) begin
        chk("fill_drain.enq_cov", 32'(enq_cov), 32'hf);
        chk("fill_drain.deq_cov", 32'(deq_cov), 32'hf);
        chk("fill_drain.both_cov", 32'(both_cov), 32'h0);
        chk("fill_drain.cnts", 32'({res_err_cnt, data_err_cnt, flag_err_cnt}), 32'h0);
      end
      if (i == 14) chk("data_err.cnt", 32'(data_err_cnt), 32'h1);
      if (i == 19) chk("flag_err.cnt", 32'(flag_err_cnt), 32'h1);
    end
    chk("both.both_cov", 32'(both_cov), 32'h7);
    chk("both.flag_cnt", 32'(flag_err_cnt), 32'h1);

    // Wrap: interleaved push/pop pairs walk the pointers around several times.
    for (int i = 0; i < 10; i++) begin
      d = 8'(8'h13 * i + 8'h05);
      drive(1, 1, d, 0, 8'h00, 0);
      step($sformatf("wrap_push%0d", i), 3'd1, 0, 0, 0);
      drive(0, 1, 8'h00, 1, d, 1);
      step($sformatf("wrap_pop%0d", i), 3'd0, 0, 0, 0);
    end

    // Reset asserted mid-stream at occupancy 3.
    drive(1, 1, 8'hc1, 0, 8'h00, 0);
    step("pre_rst1", 3'd1, 0, 0, 0);
    drive(1, 1, 8'hc2, 1, 8'hc1, 0);
    step("pre_rst2", 3'd2, 0, 0, 0);
    drive(1, 1, 8'hc3, 1, 8'hc1, 0);
    step("pre_rst3", 3'd3, 0, 0, 0);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk_all_zero("mid_reset");

    // Release with valid_o high: reset check must fire, nothing else is handled.
    drive(1, 1, 8'h5a, 1, 8'h00, 1);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step("res_check", 3'd0, 1, 0, 0);
    chk("res_check.cnt", 32'(res_err_cnt), 32'h1);
    drive(0, 1, 8'h00, 0, 8'h00, 0);
    step("res_pulse_end", 3'd0, 0, 0, 0);
    chk("res_pulse_end.cnt", 32'(res_err_cnt), 32'h1);
    drive(1, 1, 8'hc7, 0, 8'h00, 0);
    step("post_rst_push", 3'd1, 0, 0, 0);
    drive(0, 1, 8'h00, 1, 8'hc7, 1);
    step("post_rst_pop", 3'd0, 0, 0, 0);
    chk("post_rst.cnts", 32'({data_err_cnt, flag_err_cnt}), 32'h0);

    // Saturation: 2^CW+2 consecutive data errors via enq+deq at occupancy 1.
    drive(1, 1, 8'h00, 0, 8'h00, 0);
    step("sat_fill", 3'd1, 0, 0, 0);
    for (int i = 0; i < (1 << CW) + 2; i++) begin
      drive(1, 1, 8'h00, 1, 8'hff, 1);
      step($sformatf("sat%0d", i), 3'd1, 0, 1, 0);
    end
    chk("sat.data_cnt", 32'(data_err_cnt), 32'hf);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
